// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   One-entry pipeline register between decode and the 64-bit ALU. Holds the
//   decoded operands, immediate and control, selects register or immediate for
//   ALU operand b, and provides store data for the MEM stage. Valid/ready
//   handshake with stall and flush; no skid buffer.
//
//   Optional feature macro: ID_EX_FORWARD_EN
//     defined   : EX-stage forwarding from the MEM and WB producers. While
//                 stalled, the held operands are re-captured with their
//                 forwarded values so a producer leaving MEM/WB is not lost.
//     undefined : operands come straight from the held regfile values; the
//                 M/W producer ports are ignored.
//
// Ports
//   clk, reset                   clock, async active-high reset (clears all)
//   in_valid / in_ready          decode handshake
//   flush                        kill held and incoming instruction
//   rd1_d, rd2_d, imm_d          regfile read data and sign-extended immediate
//   alusrc_d, alucontrol_d       operand-b select and ALU operation
//   rn_d, rm_d, rd_d, regwrite_d source/destination indices, write enable
//   regwrite_m, rd_m, aluresult_m  MEM-stage producer
//   regwrite_w, rd_w, result_w     WB-stage producer
//   out_valid / out_ready        ALU-side handshake
//   a_e, b_e, alucontrol_e       ALU operands and operation
//   stdata_e                     store data (rm value)
//   rd_e, regwrite_e             held destination; regwrite_e gated by out_valid
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int N    = 64,
    parameter int REGW = 5,
    parameter int ACW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [N-1:0]    rd1_d,
    input  logic [N-1:0]    rd2_d,
    input  logic [N-1:0]    imm_d,
    input  logic            alusrc_d,
    input  logic [ACW-1:0]  alucontrol_d,
    input  logic [REGW-1:0] rn_d,
    input  logic [REGW-1:0] rm_d,
    input  logic [REGW-1:0] rd_d,
    input  logic            regwrite_d,
    input  logic            regwrite_m,
    input  logic [REGW-1:0] rd_m,
    input  logic [N-1:0]    aluresult_m,
    input  logic            regwrite_w,
    input  logic [REGW-1:0] rd_w,
    input  logic [N-1:0]    result_w,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    a_e,
    output logic [N-1:0]    b_e,
    output logic [ACW-1:0]  alucontrol_e,
    output logic [N-1:0]    stdata_e,
    output logic [REGW-1:0] rd_e,
    output logic            regwrite_e
);

    // Register index of XZR (all ones, 31 for REGW=5); never forwarded.
    localparam logic [REGW-1:0] XZR = '1;

    logic            vld_p1;
    logic [N-1:0]    rd1_p1;
    logic [N-1:0]    rd2_p1;
    logic [N-1:0]    imm_p1;
    logic            alusrc_p1;
    logic [ACW-1:0]  alucontrol_p1;
    logic [REGW-1:0] rn_p1;
    logic [REGW-1:0] rm_p1;
    logic [REGW-1:0] rd_p1;
    logic            regwrite_p1;

    logic            accept;
    logic            stall;
    logic [N-1:0]    fwd_a;
    logic [N-1:0]    fwd_b;

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign stall    = vld_p1 && !out_ready;

`ifdef ID_EX_FORWARD_EN
    // MEM result beats WB result; XZR always reads the held value.
    function automatic logic [N-1:0] fwd(
        input logic [REGW-1:0] src,
        input logic [N-1:0]    held,
        input logic            wr_m,
        input logic [REGW-1:0] dst_m,
        input logic [N-1:0]    res_m,
        input logic            wr_w,
        input logic [REGW-1:0] dst_w,
        input logic [N-1:0]    res_w
    );
        if (src != XZR && wr_m && dst_m == src)
            return res_m;
        else if (src != XZR && wr_w && dst_w == src)
            return res_w;
        else
            return held;
    endfunction

    always_comb begin
        fwd_a = fwd(rn_p1, rd1_p1, regwrite_m, rd_m, aluresult_m,
                    regwrite_w, rd_w, result_w);
        fwd_b = fwd(rm_p1, rd2_p1, regwrite_m, rd_m, aluresult_m,
                    regwrite_w, rd_w, result_w);
    end
`else
    always_comb begin
        fwd_a = rd1_p1;
        fwd_b = rd2_p1;
    end

    // Producer ports and held source indices have no consumer in this build.
    logic unused_fwd;
    assign unused_fwd = ^{regwrite_m, rd_m, aluresult_m,
                          regwrite_w, rd_w, result_w, rn_p1, rm_p1, XZR};
`endif

    // ---- decode -> execute boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            rd1_p1        <= '0;
            rd2_p1        <= '0;
            imm_p1        <= '0;
            alusrc_p1     <= 1'b0;
            alucontrol_p1 <= '0;
            rn_p1         <= '0;
            rm_p1         <= '0;
            rd_p1         <= '0;
            regwrite_p1   <= 1'b0;
        end else begin
            // Flush discards the held and any accepted instruction.
            if (flush)
                vld_p1 <= 1'b0;
            else if (accept)
                vld_p1 <= 1'b1;
            else if (out_ready)
                vld_p1 <= 1'b0;

            if (accept) begin
                rd1_p1        <= rd1_d;
                rd2_p1        <= rd2_d;
                imm_p1        <= imm_d;
                alusrc_p1     <= alusrc_d;
                alucontrol_p1 <= alucontrol_d;
                rn_p1         <= rn_d;
                rm_p1         <= rm_d;
                rd_p1         <= rd_d;
                regwrite_p1   <= regwrite_d;
            end
`ifdef ID_EX_FORWARD_EN
            else if (stall) begin
                // Keep forwarded values so a producer moving on is not lost.
                rd1_p1 <= fwd_a;
                rd2_p1 <= fwd_b;
            end
`endif
        end
    end

    assign out_valid    = vld_p1;
    assign a_e          = fwd_a;
    assign stdata_e     = fwd_b;
    assign b_e          = alusrc_p1 ? imm_p1 : fwd_b;
    assign alucontrol_e = alucontrol_p1;
    assign rd_e         = rd_p1;
    assign regwrite_e   = regwrite_p1 && vld_p1;

`ifndef ID_EX_FORWARD_EN
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage. Expected values for forwarding-dependent
//   checks are chosen according to whether ID_EX_FORWARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int N    = 64;
    localparam int REGW = 5;
    localparam int ACW  = 4;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [N-1:0]    rd1_d, rd2_d, imm_d;
    logic            alusrc_d;
    logic [ACW-1:0]  alucontrol_d;
    logic [REGW-1:0] rn_d, rm_d, rd_d;
    logic            regwrite_d;
    logic            regwrite_m;
    logic [REGW-1:0] rd_m;
    logic [N-1:0]    aluresult_m;
    logic            regwrite_w;
    logic [REGW-1:0] rd_w;
    logic [N-1:0]    result_w;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    a_e, b_e, stdata_e;
    logic [ACW-1:0]  alucontrol_e;
    logic [REGW-1:0] rd_e;
    logic            regwrite_e;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.N(N), .REGW(REGW), .ACW(ACW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .alusrc_d(alusrc_d), .alucontrol_d(alucontrol_d), .rn_d(rn_d),
        .rm_d(rm_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
        .regwrite_m(regwrite_m), .rd_m(rd_m), .aluresult_m(aluresult_m),
        .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
        .out_valid(out_valid), .out_ready(out_ready), .a_e(a_e), .b_e(b_e),
        .alucontrol_e(alucontrol_e), .stdata_e(stdata_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the decode-side fields of one instruction.
    task automatic offer(input logic [N-1:0] rd1, input logic [N-1:0] rd2,
                         input logic [N-1:0] imm, input logic alusrc,
                         input logic [ACW-1:0] ctl, input logic [REGW-1:0] rn,
                         input logic [REGW-1:0] rm, input logic [REGW-1:0] rd,
                         input logic regwrite);
        rd1_d = rd1; rd2_d = rd2; imm_d = imm; alusrc_d = alusrc;
        alucontrol_d = ctl; rn_d = rn; rm_d = rm; rd_d = rd;
        regwrite_d = regwrite; in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        tests++;
        if ({a_e, b_e, stdata_e} !== '0) begin fails++; $display("FAIL reset_operands: a=%h b=%h st=%h want 0", a_e, b_e, stdata_e); end
        tests++;
        if ({alucontrol_e, rd_e, regwrite_e} !== '0) begin fails++; $display("FAIL reset_ctl: ctl=%b rd=%0d rw=%b want 0", alucontrol_e, rd_e, regwrite_e); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_accept();
        out_ready = 1'b1;
        offer(64'd2, 64'd1, 64'd0, 1'b0, 4'b0010, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL accept_valid: got %b want 1", out_valid); end
        tests++;
        if (a_e !== 64'd2 || b_e !== 64'd1) begin fails++; $display("FAIL accept_ab: a=%0d b=%0d want 2 1", a_e, b_e); end
        tests++;
        if (alucontrol_e !== 4'b0010 || rd_e !== 5'd3 || regwrite_e !== 1'b1) begin
            fails++; $display("FAIL accept_ctl: ctl=%b rd=%0d rw=%b want 0010 3 1", alucontrol_e, rd_e, regwrite_e);
        end
        // Drain with nothing offered: valid drops, fields held.
        tick();
        tests++;
        if (out_valid !== 1'b0 || regwrite_e !== 1'b0) begin fails++; $display("FAIL drain_valid: v=%b rw=%b want 0 0", out_valid, regwrite_e); end
        tests++;
        if (a_e !== 64'd2) begin fails++; $display("FAIL drain_hold: a=%0d want 2", a_e); end
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        offer(64'd5, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b0111, 5'd1, 5'd2, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        tests++;
        if (b_e !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL imm_b: got %h want ffffffffffffffff", b_e); end
        tests++;
        if (stdata_e !== 64'd1) begin fails++; $display("FAIL imm_stdata: got %0d want 1", stdata_e); end
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        offer(64'd3, 64'd4, 64'd0, 1'b0, 4'b0010, 5'd5, 5'd6, 5'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        regwrite_m = 1'b1; rd_m = 5'd5; aluresult_m = 64'd7;
        regwrite_w = 1'b1; rd_w = 5'd5; result_w = 64'd9;
        #1;
        tests++;
        if (a_e !== (FWD ? 64'd7 : 64'd3)) begin fails++; $display("FAIL fwd_mem_over_wb: a=%0d want %0d", a_e, FWD ? 7 : 3); end
        regwrite_m = 1'b0;
        #1;
        tests++;
        if (a_e !== (FWD ? 64'd9 : 64'd3)) begin fails++; $display("FAIL fwd_wb: a=%0d want %0d", a_e, FWD ? 9 : 3); end
        rd_w = 5'd6;
        #1;
        tests++;
        if (a_e !== 64'd3) begin fails++; $display("FAIL fwd_none_a: a=%0d want 3", a_e); end
        tests++;
        if (stdata_e !== (FWD ? 64'd9 : 64'd4) || b_e !== (FWD ? 64'd9 : 64'd4)) begin
            fails++; $display("FAIL fwd_rm: st=%0d b=%0d want %0d", stdata_e, b_e, FWD ? 9 : 4);
        end
        regwrite_w = 1'b0;
    endtask

    task automatic test_xzr();
        out_ready = 1'b1;
        offer(64'd0, 64'd0, 64'd0, 1'b0, 4'b0000, 5'd31, 5'd31, 5'd8, 1'b1);
        tick();
        in_valid = 1'b0;
        regwrite_m = 1'b1; rd_m = 5'd31; aluresult_m = 64'd7;
        #1;
        tests++;
        if (a_e !== 64'd0 || stdata_e !== 64'd0) begin fails++; $display("FAIL xzr_no_fwd: a=%0d st=%0d want 0 0", a_e, stdata_e); end
        regwrite_m = 1'b0;
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b1;
        offer(64'd11, 64'd2, 64'd0, 1'b0, 4'b0110, 5'd4, 5'd9, 5'd10, 1'b1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        regwrite_m = 1'b1; rd_m = 5'd4; aluresult_m = 64'd7;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        tests++;
        if (a_e !== (FWD ? 64'd7 : 64'd11)) begin fails++; $display("FAIL stall_c1_a: a=%0d want %0d", a_e, FWD ? 7 : 11); end
        tick();
        regwrite_m = 1'b0;
        #1;
        tests++;
        if (a_e !== (FWD ? 64'd7 : 64'd11)) begin fails++; $display("FAIL stall_c2_a: a=%0d want %0d", a_e, FWD ? 7 : 11); end
        tick();
        tests++;
        if (out_valid !== 1'b1 || a_e !== (FWD ? 64'd7 : 64'd11)) begin
            fails++; $display("FAIL stall_c3: v=%b a=%0d want 1 %0d", out_valid, a_e, FWD ? 7 : 11);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || regwrite_e !== 1'b0) begin fails++; $display("FAIL flush_valid: v=%b rw=%b want 0 0", out_valid, regwrite_e); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        offer(64'd10, 64'd0, 64'd0, 1'b0, 4'b0000, 5'd1, 5'd2, 5'd1, 1'b1);
        tick();
        tests++;
        if (out_valid !== 1'b1 || a_e !== 64'd10 || rd_e !== 5'd1) begin
            fails++; $display("FAIL b2b_first: v=%b a=%0d rd=%0d want 1 10 1", out_valid, a_e, rd_e);
        end
        offer(64'd20, 64'd0, 64'd0, 1'b0, 4'b0001, 5'd1, 5'd2, 5'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || a_e !== 64'd20 || rd_e !== 5'd2 || alucontrol_e !== 4'b0001 || regwrite_e !== 1'b0) begin
            fails++; $display("FAIL b2b_second: v=%b a=%0d rd=%0d ctl=%b rw=%b want 1 20 2 0001 0", out_valid, a_e, rd_e, alucontrol_e, regwrite_e);
        end
    endtask

    task automatic test_flush_accept();
        out_ready = 1'b1;
        offer(64'd30, 64'd0, 64'd0, 1'b0, 4'b0010, 5'd1, 5'd2, 5'd3, 1'b1);
        flush = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_accept: v=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        offer(64'd44, 64'd55, 64'd66, 1'b1, 4'b0110, 5'd1, 5'd2, 5'd12, 1'b1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_valid_before: v=%b want 1", out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        test_reset();
        tick();
        tests++;
        if (out_valid !== 1'b0 || a_e !== 64'd0) begin fails++; $display("FAIL mid_no_recover: v=%b a=%0d want 0 0", out_valid, a_e); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rd1_d = '0; rd2_d = '0; imm_d = '0; alusrc_d = 1'b0; alucontrol_d = '0;
        rn_d = '0; rm_d = '0; rd_d = '0; regwrite_d = 1'b0;
        regwrite_m = 1'b0; rd_m = '0; aluresult_m = '0;
        regwrite_w = 1'b0; rd_w = '0; result_w = '0;
        #12;
        reset = 1'b0;
        #1;
        test_reset();
        test_accept();
        test_imm();
        test_forward();
        test_xzr();
        test_stall_flush();
        test_back_to_back();
        test_flush_accept();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
